// File: rtl/tdm_pkg.sv
// Shared definitions for the 16-channel TDM serializer: state encoding,
// channel constants and a channel-advance helper.
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int NUM_CH = 16;
  localparam int CH_W   = 4;

  localparam logic [CH_W-1:0] LAST_CH = 4'd15;

  // Channel index wraps with plain 4-bit modulo arithmetic.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return ch + 4'd1;
  endfunction

endpackage

// File: rtl/tdm_mux16_if.sv
// Bus bundle of the TDM serializer: frame request, parallel channel data
// and the registered serial-side outputs.
interface tdm_mux16_if;
  import tdm_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] data_in;
  logic              ser_out;
  logic [CH_W-1:0]   ch_idx;
  logic              bit_valid;
  logic              frame_sync;
  logic              busy;
  logic              done;

  modport master (
    output start, data_in,
    input  ser_out, ch_idx, bit_valid, frame_sync, busy, done
  );

  modport slave (
    input  start, data_in,
    output ser_out, ch_idx, bit_valid, frame_sync, busy, done
  );

endinterface

// File: rtl/tdm_mux16_slot_tick.sv
// Slot divider: counts 0..DIV-1 while run is high and flags the terminal
// count with a one-cycle tick; held at zero whenever run is low.
module slot_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = ($clog2(DIV + 1) > 1) ? $clog2(DIV + 1) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = run && (cnt_r == TERM);

  // Slot counter register; wraps on terminal count so back-to-back frames keep cadence.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!run) begin
      cnt_r <= '0;
    end else if (cnt_r == TERM) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_mux16.sv
// 16-channel TDM serializer: captures a 16-bit word on start and shifts one
// channel bit out per DIV-cycle slot, optionally repeating frames forever.
module tdm_mux16
  import tdm_pkg::*;
#(
  parameter int DIV  = 4,
  parameter bit CONT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  tdm_mux16_if.slave  bus
);

  state_t            state_r;
  state_t            state_s;
  logic [NUM_CH-1:0] shadow_r;
  logic [NUM_CH-1:0] shadow_s;
  logic [CH_W-1:0]   ch_r;
  logic [CH_W-1:0]   ch_s;
  logic              tick_s;
  logic              done_s;
  logic              sync_s;
  logic              ser_s;
  logic              send_s;

  slot_tick #(.DIV(DIV)) u_slot_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (state_r == SEND),
    .tick (tick_s)
  );

  // Next-state logic; outputs are derived from next-state values so they can be registered.
  always_comb begin
    state_s  = state_r;
    shadow_s = shadow_r;
    ch_s     = ch_r;
    done_s   = 1'b0;
    sync_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s  = SEND;
          shadow_s = bus.data_in;
          ch_s     = '0;
          sync_s   = 1'b1;
        end else begin
          ch_s = '0;
        end
      end
      SEND: begin
        if (tick_s) begin
          if (ch_r == LAST_CH) begin
            if (CONT == 1'b1) begin
              // Continuous mode: fresh capture and a new frame with no idle gap.
              shadow_s = bus.data_in;
              ch_s     = '0;
              sync_s   = 1'b1;
            end else begin
              state_s = IDLE;
              ch_s    = '0;
              done_s  = 1'b1;
            end
          end else begin
            ch_s = next_ch(ch_r);
          end
        end else begin
          ch_s = ch_r;
        end
      end
      default: begin
        state_s = IDLE;
        ch_s    = '0;
      end
    endcase
    send_s = (state_s == SEND);
    ser_s  = send_s ? shadow_s[ch_s] : 1'b0;
  end

  // State, shadow word and every output are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      shadow_r       <= '0;
      ch_r           <= '0;
      bus.ser_out    <= 1'b0;
      bus.ch_idx     <= '0;
      bus.bit_valid  <= 1'b0;
      bus.frame_sync <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state_r        <= state_s;
      shadow_r       <= shadow_s;
      ch_r           <= ch_s;
      bus.ser_out    <= ser_s;
      bus.ch_idx     <= ch_s;
      bus.bit_valid  <= send_s;
      bus.frame_sync <= sync_s;
      bus.busy       <= send_s;
      bus.done       <= done_s;
    end
  end

endmodule

// File: doc/tdm_mux16.md
TDM_MUX16 -- requirements
Module: tdm_mux16

Interface
REQ-001 Parameter DIV, default 4: clock cycles each channel bit is held on ser_out; legal range 1..255.
REQ-002 Parameter CONT, default 0: 0 = one frame per start, 1 = frames repeat back-to-back until reset.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 data_in  input  16  parallel channel data; bit k is channel k.
REQ-007 ser_out  output  1  serial stream, one channel bit per slot.
REQ-008 ch_idx  output  4  channel number currently on ser_out.
REQ-009 bit_valid  output  1  high while ser_out carries a channel bit.
REQ-010 frame_sync  output  1  one-cycle pulse on the first cycle of channel 0.
REQ-011 busy  output  1  high in SEND.
REQ-012 done  output  1  one-cycle pulse after the last slot of a single-frame transfer.

Function
REQ-013 The FSM SHALL have two states: IDLE and SEND.
REQ-014 IDLE with start=1 at edge n SHALL capture data_in into a 16-bit shadow register and enter SEND at edge n.
  - From cycle n+1: ser_out=shadow[0], ch_idx=0, bit_valid=1, frame_sync=1.
REQ-015 The slot counter SHALL count 0..DIV-1; on its terminal count ch_idx SHALL increment by 1.
  - Each channel therefore occupies exactly DIV cycles.
  - A full frame lasts 16*DIV cycles.
REQ-016 ser_out SHALL always equal shadow[ch_idx] while in SEND; data_in changes during SEND SHALL NOT affect the current frame.
REQ-017 frame_sync SHALL be high only on the first cycle of channel 0 of each frame and low on all other cycles.
REQ-018 End of channel 15, CONT=0: SHALL return to IDLE and assert done for exactly the first IDLE cycle.
  - In that cycle bit_valid=0, busy=0, ser_out=0, ch_idx=0.
REQ-019 End of channel 15, CONT=1: SHALL recapture data_in on the same edge, wrap ch_idx 15->0 and pulse frame_sync with no idle gap; done SHALL stay 0.
REQ-020 start asserted while in SEND SHALL be ignored, with no queuing.
REQ-021 start held high through the done cycle SHALL begin a new frame from the done cycle.
  - Result: one idle cycle between frames.
REQ-022 In IDLE: ser_out=0, ch_idx=0, bit_valid=0, frame_sync=0, busy=0.
REQ-023 DIV=1 SHALL advance one channel per clock.
  - ch_idx wrap-around SHALL use 4-bit modulo arithmetic.
  - The slot counter SHALL be ceil(log2(DIV+1)) bits wide, minimum 1.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, clear the shadow register, slot counter and ch_idx, and drive every output to 0.
  - rst has priority over start and over any in-progress frame.
REQ-025 A frame aborted by rst SHALL NOT produce done; the first start after rst is released SHALL be honoured normally.

Structure
REQ-026 A shared package tdm_pkg SHALL hold:
  - the state encoding (IDLE=0, SEND=1);
  - constants NUM_CH=16 and CH_W=4.
REQ-027 The slot counter SHALL be one sub-module, slot_tick. It is parameterized by DIV, has inputs clk, rst and run, and outputs a one-cycle tick on its terminal count.
REQ-028 All outputs SHALL be registered; no combinational path SHALL exist from start or data_in to any output.

Verification
REQ-029 DIV=4, CONT=0, data_in=16'hA5C3, start pulse -> ser_out bit k equals bit k of A5C3 for 4 cycles each, ch_idx 0..15, 64 cycles with bit_valid=1, then done=1 for 1 cycle.
REQ-030 DIV=1, CONT=1, data_in=16'h0001 then 16'h8000 from mid-frame 1 -> frame 1 sends 0001, frame 2 sends 8000, frame_sync every 16 cycles, no gap, done never high.
REQ-031 DIV=2, CONT=0, start re-pulsed at ch_idx=7 -> ignored; frame ends at cycle 32 and only one done.
REQ-032 DIV=3, rst asserted at ch_idx=9 -> next cycle all outputs 0 in IDLE, no done; a following start sends a full frame from ch 0.
REQ-033 DIV=4, CONT=0, start held high continuously -> frames of 64 bit_valid cycles separated by exactly one done/idle cycle.
REQ-034 DIV=4, data_in toggled every cycle during SEND -> ser_out matches only the value captured at the start edge.
